conv_window_gen: RTL and testbench



---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_window_gen_if.sv | 27 ++
 rtl/conv_window_mult.sv | 22 ++
 rtl/conv_window_gen.sv | 164 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution window producer and MAC.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    EMIT,
    DONE
  } conv_state_t;

  // Output side length of a valid (unpadded) convolution.
  function automatic int unsigned ofmap_size(input int unsigned ifmap,
                                             input int unsigned filter,
                                             input int unsigned stride);
    return (ifmap - filter) / stride + 1;
  endfunction

  // Counter/index width for n entries, never below one bit.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Load stream (in_*) and window stream (out_*) of conv_window_gen.
interface conv_window_gen_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NTAPS = 9,
  parameter int unsigned IW    = 4
);
  logic                            in_valid;
  logic                            in_ready;
  logic [DW-1:0]                   in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NTAPS-1:0][2*DW-1:0]      out_products;
  logic [IW-1:0]                   out_index;
  logic                            out_last;

  // Environment side: feeds weights/pixels, consumes windows.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_products, out_index, out_last
  );

  // Block side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_products, out_index, out_last
  );
endinterface

// File: rtl/conv_window_mult.sv
// Element-wise products of one pixel window and the filter weights.
module conv_window_mult
  import conv_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned NTAPS = 9
) (
  input  logic [NTAPS-1:0][DW-1:0]   win,
  input  logic [NTAPS-1:0][DW-1:0]   wts,
  output logic [NTAPS-1:0][2*DW-1:0] prods
);
  localparam int unsigned KW  = cw(NTAPS);
  localparam int unsigned PDW = 2 * DW;

  // Full-width unsigned product per tap.
  always_comb begin
    prods = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      prods[KW'(k)] = PDW'(win[KW'(k)]) * PDW'(wts[KW'(k)]);
    end
  end
endmodule

// File: rtl/conv_window_gen.sv
// Loads a filter and an ifmap, then streams the per-window tap products
// in raster order of output positions.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IP_DATA_WIDTH = 8,
  parameter int unsigned IFMAP_SIZE    = 5,
  parameter int unsigned FILTER_SIZE   = 3,
  parameter int unsigned STRIDE        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  conv_window_gen_if.slave    bus
);
  localparam int unsigned OFMAP_SIZE = ofmap_size(IFMAP_SIZE, FILTER_SIZE, STRIDE);
  localparam int unsigned NTAPS = FILTER_SIZE * FILTER_SIZE;
  localparam int unsigned NPIX  = IFMAP_SIZE * IFMAP_SIZE;
  localparam int unsigned NOUT  = OFMAP_SIZE * OFMAP_SIZE;
  localparam int unsigned DW    = IP_DATA_WIDTH;
  localparam int unsigned WW    = cw(NTAPS);
  localparam int unsigned PW    = cw(NPIX);
  localparam int unsigned OW    = cw(OFMAP_SIZE);
  localparam int unsigned IW    = cw(NOUT);

  localparam logic [WW-1:0] W_LAST  = WW'(NTAPS - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(NPIX - 1);
  localparam logic [OW-1:0] O_LAST  = OW'(OFMAP_SIZE - 1);

  conv_state_t state, state_nx;

  logic [WW-1:0]                wcnt;
  logic [PW-1:0]                pcnt;
  logic [NTAPS-1:0][DW-1:0]     w_buf;
  logic [DW-1:0]                x_buf [NPIX];
  logic [OW-1:0]                oy, ox;
  logic [OW-1:0]                sy, sx;
  logic [IW-1:0]                sidx;
  logic                         slast;
  logic [NTAPS-1:0][DW-1:0]     win;
  logic [NTAPS-1:0][2*DW-1:0]   prods;
  logic [PW-1:0]                addr;
  logic                         in_beat, out_beat, w_beat, x_beat, x_final, load_win;

  assign in_beat  = bus.in_valid & bus.in_ready;
  assign out_beat = bus.out_valid & bus.out_ready;
  assign w_beat   = in_beat & (state == LOAD_W);
  assign x_beat   = in_beat & (state == LOAD_X);
  assign x_final  = x_beat & (pcnt == P_LAST);
  assign load_win = x_final | ((state == EMIT) & out_beat & ~bus.out_last);

  assign bus.in_ready  = (state == LOAD_W) | (state == LOAD_X);
  assign bus.out_valid = (state == EMIT);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD_W;
      LOAD_W:  if (w_beat && wcnt == W_LAST) state_nx = LOAD_X;
      LOAD_X:  if (x_final) state_nx = EMIT;
      EMIT:    if (out_beat && bus.out_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Load counters, cleared when a job is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      pcnt <= '0;
    end else if (state == IDLE && start) begin
      wcnt <= '0;
      pcnt <= '0;
    end else begin
      if (w_beat) wcnt <= wcnt + 1'b1;
      if (x_beat) pcnt <= pcnt + 1'b1;
    end
  end

  // Weight buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      w_buf <= '0;
    else if (w_beat) w_buf[wcnt] <= bus.in_data;
  end

  // Pixel buffer, raster order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NPIX; i++) x_buf[i] <= '0;
    end else if (x_beat) begin
      x_buf[pcnt] <= bus.in_data;
    end
  end

  // Coordinates of the window to be loaded next: origin while loading pixels,
  // otherwise the successor of the one being presented.
  always_comb begin
    sx   = '0;
    sy   = '0;
    sidx = '0;
    if (state == EMIT) begin
      if (ox == O_LAST) begin
        sx = '0;
        sy = oy + 1'b1;
      end else begin
        sx = ox + 1'b1;
        sy = oy;
      end
      sidx = bus.out_index + 1'b1;
    end
    slast = (sy == O_LAST) && (sx == O_LAST);
  end

  // Window mux. The first window is captured on the edge that writes the
  // final pixel, so a pixel being written this cycle is forwarded from in_data.
  always_comb begin
    win  = '0;
    addr = '0;
    for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
      for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
        addr = PW'((int'(sy) * STRIDE + r) * IFMAP_SIZE + int'(sx) * STRIDE + c);
        win[WW'(r * FILTER_SIZE + c)] = (x_beat && addr == pcnt) ? bus.in_data : x_buf[addr];
      end
    end
  end

  conv_window_mult #(
    .DW    (DW),
    .NTAPS (NTAPS)
  ) u_mult (
    .win   (win),
    .wts   (w_buf),
    .prods (prods)
  );

  // Output window registers; hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oy               <= '0;
      ox               <= '0;
      bus.out_products <= '0;
      bus.out_index    <= '0;
      bus.out_last     <= 1'b0;
    end else if (load_win) begin
      oy               <= sy;
      ox               <= sx;
      bus.out_products <= prods;
      bus.out_index    <= sidx;
      bus.out_last     <= slast;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with the default 5x5 ifmap / 3x3 filter.
module tb_conv_window_gen;
  localparam int unsigned NT = 9;
  localparam int unsigned VW = NT * 16;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  conv_window_gen_if #(.DW(8), .NTAPS(NT), .IW(4)) bus ();

  conv_window_gen #(
    .IP_DATA_WIDTH (8),
    .IFMAP_SIZE    (5),
    .FILTER_SIZE   (3),
    .STRIDE        (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]    w_m [NT];
  logic [7:0]    x_m [25];
  logic [VW-1:0] cap [NT];

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference window for output position i.
  function automatic logic [VW-1:0] exp_win(input int unsigned i);
    logic [VW-1:0] v;
    int unsigned oy, ox, r, c;
    logic [15:0] p;
    v  = '0;
    oy = i / 3;
    ox = i % 3;
    for (int unsigned k = 0; k < NT; k++) begin
      r = k / 3;
      c = k % 3;
      p = 16'(x_m[(oy + r) * 5 + ox + c]) * 16'(w_m[k]);
      v[k*16 +: 16] = p;
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] pack9(input int unsigned h [NT]);
    logic [VW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NT; k++) v[k*16 +: 16] = 16'(h[k]);
    return v;
  endfunction

  task automatic set_ramp_ones();
    for (int k = 0; k < 9; k++) w_m[k] = 8'd1;
    for (int p = 0; p < 25; p++) x_m[p] = 8'(p);
  endtask

  task automatic load_job(input bit gappy, input int n_pix);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", VW'(busy), VW'(1));
    check("ready_after_start", VW'(bus.in_ready), VW'(1));
    for (int b = 0; b < 9 + n_pix; b++) begin
      if (gappy) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (b < 9) ? w_m[b] : x_m[b-9];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_at, input bit poke_start);
    int  got;
    int  cyc;
    bit  stalled;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    bus.out_ready = 1'b1;
    check("ready_low_in_emit", VW'(bus.in_ready), VW'(0));
    while (got < 9 && cyc < 100) begin
      if (bus.out_valid) begin
        if (got == stall_at && !stalled) begin
          stalled = 1'b1;
          bus.out_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            check("stall_index", VW'(bus.out_index), VW'(got));
            check("stall_products", bus.out_products, exp_win(got));
          end
          bus.out_ready = 1'b1;
        end
        check("win_index", VW'(bus.out_index), VW'(got));
        check("win_products", bus.out_products, exp_win(got));
        check("win_last", VW'(bus.out_last), VW'(got == 8));
        cap[got] = bus.out_products;
        got++;
      end
      start = (poke_start && got == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("windows_received", VW'(got), VW'(9));
    check("emit_cycles", VW'(cyc), VW'(9));
    check("done_after_last", VW'(done), VW'(1));
    check("busy_in_done", VW'(busy), VW'(1));
    @(posedge clk); #1;
    check("done_one_cycle", VW'(done), VW'(0));
    check("busy_cleared", VW'(busy), VW'(0));
    check("valid_cleared", VW'(bus.out_valid), VW'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  VW'(bus.in_ready),  VW'(0));
    check({tag, "_out_valid"}, VW'(bus.out_valid), VW'(0));
    check({tag, "_products"},  bus.out_products,   '0);
    check({tag, "_index"},     VW'(bus.out_index), VW'(0));
    check({tag, "_last"},      VW'(bus.out_last),  VW'(0));
    check({tag, "_busy"},      VW'(busy),          VW'(0));
    check({tag, "_done"},      VW'(done),          VW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned h [NT];
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: unit weights, ramp ifmap.
    set_ramp_ones();
    load_job(1'b0, 25);
    collect(-1, 1'b0);
    h = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    check("t1_i0_hand", cap[0], pack9(h));
    h = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    check("t1_i8_hand", cap[8], pack9(h));

    // Test 2: ramp weights, saturated pixels.
    for (int k = 0; k < 9; k++) w_m[k] = 8'(k);
    for (int p = 0; p < 25; p++) x_m[p] = 8'd255;
    load_job(1'b0, 25);
    collect(-1, 1'b0);
    h = '{0, 255, 510, 765, 1020, 1275, 1530, 1785, 2040};
    check("t2_i4_hand", cap[4], pack9(h));

    // Test 3: full-scale products with a consumer stall at window 4.
    for (int k = 0; k < 9; k++) w_m[k] = 8'd255;
    load_job(1'b0, 25);
    collect(4, 1'b0);
    h = '{65025, 65025, 65025, 65025, 65025, 65025, 65025, 65025, 65025};
    check("t3_i8_hand", cap[8], pack9(h));

    // Test 4: gapped loads, stray start during emission.
    set_ramp_ones();
    load_job(1'b1, 25);
    collect(-1, 1'b1);
    h = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    check("t4_i0_hand", cap[0], pack9(h));
    @(posedge clk); #1;
    check("t4_start_ignored", VW'(busy), VW'(0));

    // Test 5: reset while pixel 12 is on the bus, then a clean job.
    for (int k = 0; k < 9; k++) w_m[k] = 8'd3;
    load_job(1'b0, 12);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    #3;
    rst_n = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    check_reset_values("midload");
    @(posedge clk); #1;
    check("midload_held_valid", VW'(bus.out_valid), VW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_ramp_ones();
    load_job(1'b0, 25);
    collect(-1, 1'b0);
    h = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    check("t5_i8_hand", cap[8], pack9(h));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
